// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int          DIV_ITERS = 32;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    // Magnitude of v when treated as signed (sgn=1); INT_MIN maps to 2^31 unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step (
    input  logic [32:0] rem,
    input  logic [31:0] quo,
    input  logic [31:0] divisor,
    output logic [32:0] rem_next,
    output logic [31:0] quo_next
);

    logic [33:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {2'b00, divisor};
        // Borrow out of the trial subtraction means the divisor did not fit: restore.
        if (!diff[33]) begin
            rem_next = diff[32:0];
            quo_next = {quo[30:0], 1'b1};
        end else begin
            rem_next = shifted[32:0];
            quo_next = {quo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execute unit: registered multiply, iterative restoring divide.
// Optional macro DIV_EARLY_OUT_EN lets trivial divides skip the iteration and fix-up states.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int          N        = DIV_ITERS / DIV_BITS_PER_CYCLE;
    localparam logic [4:0]  CNT_INIT = 5'(N - 1);

    muldiv_state_e state_reg, state_next;
    muldiv_op_e    op_reg;
    logic [31:0]   a_reg, b_reg;
    logic [32:0]   rem_reg;
    logic [31:0]   quo_reg;
    logic [4:0]    cnt_reg;
    logic [63:0]   prod_reg;
    logic [31:0]   result_reg;
    logic          done_reg;

    logic          accept;
    logic          early;
    logic [32:0]   init_rem;
    logic [31:0]   init_quo;
    logic          div_signed;
    logic [31:0]   b_mag;
    logic [63:0]   mul_a, mul_b, mul_prod;
    logic [31:0]   fix_quo, fix_rem;
    logic [31:0]   result_sel;

    logic [32:0]   rem_chain [0:DIV_BITS_PER_CYCLE];
    logic [31:0]   quo_chain [0:DIV_BITS_PER_CYCLE];

    // The done cycle still counts as busy, so a new start is only taken once done has dropped.
    assign accept = start && !kill && (state_reg == S_IDLE) && !done_reg;
    assign busy   = (state_reg != S_IDLE) || done_reg;
    assign done   = done_reg;
    assign result = result_reg;

    // Initial divider contents at accept; early-out divides load their final answer directly.
    always_comb begin
        early    = 1'b0;
        init_rem = 33'd0;
        init_quo = abs32(a, ~op[0]);
`ifdef DIV_EARLY_OUT_EN
        if (op[2]) begin
            if (b == 32'd0) begin
                early    = 1'b1;
                init_quo = NEG_ONE;
                init_rem = {1'b0, a};
            end else if (!op[0] && (a == INT_MIN) && (b == NEG_ONE)) begin
                early    = 1'b1;
                init_quo = INT_MIN;
                init_rem = 33'd0;
            end else if (abs32(b, ~op[0]) > abs32(a, ~op[0])) begin
                early    = 1'b1;
                init_quo = 32'd0;
                init_rem = {1'b0, a};
            end
        end
`endif
    end

    always_comb begin
        state_next = state_reg;
        if (kill) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (accept) state_next = !op[2] ? S_MUL : (early ? S_DONE : S_DIV);
                S_MUL:  state_next = S_DONE;
                S_DIV:  if (cnt_reg == 5'd0) state_next = S_FIX;
                S_FIX:  state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Operands are extended to 64 bits by signedness so one unsigned multiply covers all four ops.
    assign div_signed = ~op_reg[0];
    assign b_mag      = abs32(b_reg, div_signed);
    assign mul_a      = {{32{(op_reg != OP_MULHU) && a_reg[31]}}, a_reg};
    assign mul_b      = {{32{(op_reg == OP_MUL || op_reg == OP_MULH) && b_reg[31]}}, b_reg};
    assign mul_prod   = mul_a * mul_b;

    assign rem_chain[0] = rem_reg;
    assign quo_chain[0] = quo_reg;

    generate
        for (genvar gi = 0; gi < DIV_BITS_PER_CYCLE; gi++) begin : g_step
            div_step u_step (
                .rem      (rem_chain[gi]),
                .quo      (quo_chain[gi]),
                .divisor  (b_mag),
                .rem_next (rem_chain[gi+1]),
                .quo_next (quo_chain[gi+1])
            );
        end
    endgenerate

    always_comb begin
        fix_quo = ((div_signed && a_reg[31]) ^ (div_signed && b_reg[31])) ? (~quo_reg + 32'd1) : quo_reg;
        fix_rem = (div_signed && a_reg[31]) ? (~rem_reg[31:0] + 32'd1) : rem_reg[31:0];
        if (b_reg == 32'd0) begin
            fix_quo = NEG_ONE;
            fix_rem = a_reg;
        end else if (div_signed && (a_reg == INT_MIN) && (b_reg == NEG_ONE)) begin
            fix_quo = INT_MIN;
            fix_rem = 32'd0;
        end
    end

    always_comb begin
        case (op_reg)
            OP_MUL:                 result_sel = prod_reg[31:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:               result_sel = prod_reg[63:32];
            OP_DIV, OP_DIVU:        result_sel = quo_reg;
            default:                result_sel = rem_reg[31:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg     <= OP_MUL;
            a_reg      <= '0;
            b_reg      <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            cnt_reg    <= '0;
            prod_reg   <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                op_reg  <= muldiv_op_e'(op);
                a_reg   <= a;
                b_reg   <= b;
                cnt_reg <= CNT_INIT;
                rem_reg <= init_rem;
                quo_reg <= init_quo;
            end else if (!kill) begin
                case (state_reg)
                    S_MUL: prod_reg <= mul_prod;
                    S_DIV: begin
                        rem_reg <= rem_chain[DIV_BITS_PER_CYCLE];
                        quo_reg <= quo_chain[DIV_BITS_PER_CYCLE];
                        cnt_reg <= cnt_reg - 5'd1;
                    end
                    S_FIX: begin
                        quo_reg <= fix_quo;
                        rem_reg <= {1'b0, fix_rem};
                    end
                    S_DONE: begin
                        result_reg <= result_sel;
                        done_reg   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
